arbiter_switch_alloc: RTL and testbench
=======================================

# arbiter_switch_alloc

Switch allocator for one 3D-mesh router. It takes the per-input routing decision produced by the XYZ routing stage, along with the downstream FIFO status, and grants output ports one packet at a time in wormhole fashion. Grants use per-output round-robin arbitration. The block drives the crossbar select lines and pops the input FIFOs. It sits between the XYZ routing stage and the crossbar/output FIFOs.

## Interface
Parameters:
- NPORT, 7: number of ports. Fixed; the index order comes from the shared `IDX_*` constants (IP, W, E, S, N, D, U).
- SEL_W, 3: width of one crossbar select field.

Ports:
- clk  in  1  router clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  NPORT  input FIFO i non-empty
- in_head  in  NPORT  flit at head of FIFO i is a head flit
- in_tail  in  NPORT  flit at head of FIFO i is a tail flit (head and tail both set = single-flit packet)
- in_fwd  in  NPORT*NPORT  forward vector of input i, at [i*NPORT +: NPORT], from XYZ routing
- out_ready  in  NPORT  downstream FIFO o not full
- in_pop  out  NPORT  flit of input i transfers this cycle
- out_valid  out  NPORT  flit is written to output o this cycle
- xbar_sel  out  NPORT*SEL_W  input index driving output o, at [o*SEL_W +: SEL_W]
- route_err  out  NPORT  registered one-cycle pulse: input i presented a head flit with a non-one-hot in_fwd

## Operation
- Each output o has its own state machine, owner register (SEL_W bits) and round-robin pointer ptr_o.
- States:
  - IDLE: no owner.
  - LOCKED: owner_o holds the output until its tail flit transfers.
- Request: req[i][o] = in_valid[i] & in_head[i] & onehot(in_fwd[i]) & in_fwd[i][o] & ~input_busy[i].
  - input_busy[i] = input i is the owner of some LOCKED output.
- IDLE -> LOCKED: at least one req[*][o].
  - The winner is the first requester scanning (ptr_o+1) mod 7 upward, with wrap.
  - owner_o <= winner.
  - No transfer happens in the arbitration cycle.
- LOCKED, transfer condition: in_valid[owner] & out_ready[o].
  - When it holds: out_valid[o]=1 and in_pop[owner]=1.
  - out_valid, in_pop and xbar_sel are combinational from state, owner, in_valid and out_ready.
- LOCKED -> IDLE: a transfer of a flit with in_tail[owner]=1.
  - On that edge ptr_o <= owner.
- Conflicts cannot arise:
  - An input requests exactly one output.
  - An input already owning an output is masked from requesting.
  - Therefore at most one output can grant any input.
- Error path: a head flit with in_fwd equal to zero or multi-hot is never granted.
  - route_err[i] pulses the cycle after it is presented and stays asserted each cycle that condition persists.
  - Upstream is responsible for flushing.
- Body flits (in_head=0) presented to a non-owning output are ignored.

## Timing
- Reset (async assert, sync-released use):
  - All outputs go IDLE, owner=0, ptr_o=6 (first priority is index 0, IP).
  - in_pop=0, out_valid=0, xbar_sel=0, route_err=0.
- Latency: head visible at cycle t -> grant registered at edge t+1 -> first transfer in cycle t+1 if out_ready.
  - A minimum 1-cycle arbitration bubble applies per packet.
- Throughput while LOCKED: one flit per cycle.
  - out_ready=0 or in_valid[owner]=0 stalls with no pop and the lock held.
- Tail transfer and a new head on the same output in the same cycle: the release takes effect at the clock edge; the new arbitration happens the next cycle, giving exactly one idle cycle.
- A single-flit packet occupies the output for exactly 2 cycles: arbitration, then transfer.
- Reset mid-packet drops all locks immediately. The remaining body flits are treated as stray body flits and ignored.

## Structure
- Shared header design_params.vh holds:
  - `IDX_IP`..`IDX_U`
  - NPORT and SEL_W
  - state encodings `ALLOC_IDLE`=0 and `ALLOC_LOCKED`=1
- Sub-module arbiter_rr7: 7-bit request vector plus 3-bit pointer in, 3-bit winner index plus any-grant flag out. Purely combinational.
- Instantiate 7 copies of arbiter_rr7, one per output.
- The onehot check and the in_pop OR-reduction live in the top module.

## Test plan
- Single-flit IP->E:
  - Stimulus: in_valid/head/tail[`IDX_IP`]=1, in_fwd[IP]=1<<`IDX_E`, out_ready all 1.
  - Required: cycle 1 has out_valid[E]=1, in_pop[IP]=1, xbar_sel[E]=`IDX_IP`; output E is IDLE at cycle 2.
- Contention after reset:
  - Stimulus: inputs W and N each present a 3-flit packet to IP in the same cycle.
  - Required: the lower index wins. Its 3 flits transfer in cycles 1-3, one idle cycle follows, and the other input's flits transfer in cycles 5-7.
- Backpressure:
  - Stimulus: a 4-flit packet, with out_ready low for cycles 2-3.
  - Required: no in_pop or out_valid in those cycles, lock held, all 4 flits delivered by cycle 6.
- Fairness:
  - Stimulus: inputs 1, 3 and 5 continuously send single-flit packets to U.
  - Required: grant order 1, 3, 5, 1, 3, 5…; no input is starved over 30 packets.
- Route error:
  - Stimulus: a head flit on S with in_fwd=7'b0000011.
  - Required: route_err[S]=1 from the next cycle, no grant on any output.
- Async reset mid-packet:
  - Stimulus: assert rst_n low during flit 2 of a 5-flit packet.
  - Required: all outputs are zero immediately. After release, the remaining body flits are ignored, and a new head is granted normally with priority starting at IP.

Source files
------------

// File: rtl/arbiter_switch_alloc_pkg.sv
// Shared constants, state encoding and helpers for the 3D-mesh switch allocator.
package arbiter_switch_alloc_pkg;

  localparam int unsigned NPORT = 7;
  localparam int unsigned SEL_W = 3;

  localparam int unsigned IDX_IP = 0;
  localparam int unsigned IDX_W  = 1;
  localparam int unsigned IDX_E  = 2;
  localparam int unsigned IDX_S  = 3;
  localparam int unsigned IDX_N  = 4;
  localparam int unsigned IDX_D  = 5;
  localparam int unsigned IDX_U  = 6;

  typedef enum logic {
    AllocIdle   = 1'b0,
    AllocLocked = 1'b1
  } alloc_state_e;

  function automatic logic is_onehot(logic [NPORT-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/arbiter_switch_alloc_if.sv
// Routing-stage / crossbar side signals of the switch allocator.
interface arbiter_switch_alloc_if;
  import arbiter_switch_alloc_pkg::*;

  logic [NPORT-1:0]       in_valid;
  logic [NPORT-1:0]       in_head;
  logic [NPORT-1:0]       in_tail;
  logic [NPORT*NPORT-1:0] in_fwd;
  logic [NPORT-1:0]       out_ready;
  logic [NPORT-1:0]       in_pop;
  logic [NPORT-1:0]       out_valid;
  logic [NPORT*SEL_W-1:0] xbar_sel;
  logic [NPORT-1:0]       route_err;

  modport master (
    output in_valid, in_head, in_tail, in_fwd, out_ready,
    input  in_pop, out_valid, xbar_sel, route_err
  );

  modport slave (
    input  in_valid, in_head, in_tail, in_fwd, out_ready,
    output in_pop, out_valid, xbar_sel, route_err
  );

endinterface

// File: rtl/arbiter_switch_alloc_rr7.sv
// Combinational 7-way round-robin pick: first request strictly after ptr_i, wrapping.
module arbiter_rr7
  import arbiter_switch_alloc_pkg::*;
(
  input  logic [NPORT-1:0] req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [SEL_W-1:0] winner_o,
  output logic             grant_o
);

  logic found;

  always_comb begin
    found    = 1'b0;
    winner_o = '0;
    for (int k = 1; k <= int'(NPORT); k++) begin
      if (!found && req_i[(int'(ptr_i) + k) % int'(NPORT)]) begin
        found    = 1'b1;
        winner_o = SEL_W'((int'(ptr_i) + k) % int'(NPORT));
      end
    end
    grant_o = found;
  end

endmodule

// File: rtl/arbiter_switch_alloc.sv
// Wormhole switch allocator: per-output lock FSM with round-robin grant, drives
// crossbar selects and input FIFO pops.
module arbiter_switch_alloc
  import arbiter_switch_alloc_pkg::*;
(
  input logic                   clk,
  input logic                   rst_n,
  arbiter_switch_alloc_if.slave bus
);

  alloc_state_e     state_q [NPORT];
  alloc_state_e     state_d [NPORT];
  logic [SEL_W-1:0] owner_q [NPORT];
  logic [SEL_W-1:0] owner_d [NPORT];
  logic [SEL_W-1:0] ptr_q   [NPORT];
  logic [SEL_W-1:0] ptr_d   [NPORT];
  logic [NPORT-1:0] route_err_q, route_err_d;

  logic [NPORT-1:0] fwd [NPORT];
  logic [NPORT-1:0] req [NPORT];  // indexed by output, one bit per input
  logic [SEL_W-1:0] win [NPORT];
  logic [NPORT-1:0] grant;
  logic [NPORT-1:0] fwd_ok, busy, xfer, pop;
  logic [NPORT*SEL_W-1:0] sel;

  always_comb begin
    busy = '0;
    for (int i = 0; i < int'(NPORT); i++) begin
      fwd[i]    = bus.in_fwd[i*NPORT +: NPORT];
      fwd_ok[i] = is_onehot(fwd[i]);
      for (int o = 0; o < int'(NPORT); o++) begin
        if (state_q[o] == AllocLocked && owner_q[o] == SEL_W'(i)) busy[i] = 1'b1;
      end
    end
    for (int o = 0; o < int'(NPORT); o++) begin
      for (int i = 0; i < int'(NPORT); i++) begin
        req[o][i] = bus.in_valid[i] & bus.in_head[i] & fwd_ok[i] & fwd[i][o] & ~busy[i];
      end
    end
    route_err_d = bus.in_valid & bus.in_head & ~fwd_ok;
  end

  for (genvar o = 0; o < int'(NPORT); o++) begin : g_arb
    arbiter_rr7 u_arb (
      .req_i    (req[o]),
      .ptr_i    (ptr_q[o]),
      .winner_o (win[o]),
      .grant_o  (grant[o])
    );
  end

  always_comb begin
    xfer = '0;
    pop  = '0;
    sel  = '0;
    for (int o = 0; o < int'(NPORT); o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      if (state_q[o] == AllocLocked) begin
        sel[o*SEL_W +: SEL_W] = owner_q[o];
        xfer[o] = bus.in_valid[owner_q[o]] & bus.out_ready[o];
        if (xfer[o]) pop[owner_q[o]] = 1'b1;
      end
      unique case (state_q[o])
        AllocIdle: begin
          // Grant only locks the output; the first flit moves next cycle.
          if (grant[o]) begin
            state_d[o] = AllocLocked;
            owner_d[o] = win[o];
          end
        end
        AllocLocked: begin
          if (xfer[o] && bus.in_tail[owner_q[o]]) begin
            state_d[o] = AllocIdle;
            ptr_d[o]   = owner_q[o];
          end
        end
        default: state_d[o] = AllocIdle;
      endcase
    end
  end

  assign bus.in_pop    = pop;
  assign bus.out_valid = xfer;
  assign bus.xbar_sel  = sel;
  assign bus.route_err = route_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < int'(NPORT); o++) begin
        state_q[o] <= AllocIdle;
        owner_q[o] <= '0;
        ptr_q[o]   <= SEL_W'(IDX_U);
      end
      route_err_q <= '0;
    end else begin
      for (int o = 0; o < int'(NPORT); o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
      route_err_q <= route_err_d;
    end
  end

endmodule

// File: tb/tb_arbiter_switch_alloc.sv
// Randomized plus directed bench for arbiter_switch_alloc against a packet-level
// reference model of ownership, round-robin order and flit queues.
module tb_arbiter_switch_alloc;
  import arbiter_switch_alloc_pkg::*;

  typedef struct packed {
    logic             head;
    logic             tail;
    logic [NPORT-1:0] fwd;
  } flit_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  arbiter_switch_alloc_if bus ();

  arbiter_switch_alloc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  flit_t fq [NPORT][$];
  int own [NPORT];           // -1 when the output is free
  int ptr [NPORT];           // last input served per output
  logic [NPORT-1:0] err_m;

  localparam logic [NPORT-1:0] ALL1 = '1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NPORT); i++) begin
      own[i] = -1;
      ptr[i] = int'(IDX_U);
    end
    err_m = '0;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check_eq({tag, "_in_pop"}, 64'(bus.in_pop), 64'd0);
    check_eq({tag, "_xbar_sel"}, 64'(bus.xbar_sel), 64'd0);
    check_eq({tag, "_route_err"}, 64'(bus.route_err), 64'd0);
  endtask

  task automatic push_pkt(input int i, input int len, input logic [NPORT-1:0] fwd);
    for (int f = 0; f < len; f++) begin
      flit_t fl;
      fl.head = (f == 0);
      fl.tail = (f == len - 1);
      fl.fwd  = fwd;
      fq[i].push_back(fl);
    end
  endtask

  // One clock cycle: drive from queues, compare against the model, advance the model.
  task automatic run_cycle(input logic [NPORT-1:0] rdy, input logic [NPORT-1:0] vmask,
                           input bit rst_mid);
    logic [NPORT-1:0] v, h, t, xfer, pop, busy, nerr;
    logic [NPORT*NPORT-1:0] fw;
    logic [NPORT*SEL_W-1:0] sel;
    int nown [NPORT];
    fw = '0;
    for (int i = 0; i < int'(NPORT); i++) begin
      v[i] = 1'b0; h[i] = 1'b0; t[i] = 1'b0;
      if (fq[i].size() > 0 && vmask[i]) begin
        v[i] = 1'b1;
        h[i] = fq[i][0].head;
        t[i] = fq[i][0].tail;
        fw[i*NPORT +: NPORT] = fq[i][0].fwd;
      end
    end
    bus.in_valid  = v;
    bus.in_head   = h;
    bus.in_tail   = t;
    bus.in_fwd    = fw;
    bus.out_ready = rdy;
    #1;
    xfer = '0; pop = '0; sel = '0; busy = '0;
    for (int o = 0; o < int'(NPORT); o++) begin
      if (own[o] >= 0) begin
        busy[own[o]] = 1'b1;
        sel[o*SEL_W +: SEL_W] = SEL_W'(own[o]);
        if (v[own[o]] && rdy[o]) begin
          xfer[o] = 1'b1;
          pop[own[o]] = 1'b1;
        end
      end
    end
    check_eq("out_valid", 64'(bus.out_valid), 64'(xfer));
    check_eq("in_pop", 64'(bus.in_pop), 64'(pop));
    check_eq("xbar_sel", 64'(bus.xbar_sel), 64'(sel));
    check_eq("route_err", 64'(bus.route_err), 64'(err_m));
    if (rst_mid) begin
      rst_n = 1'b0;
      #1;
      check_quiet("mid_reset");
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    for (int i = 0; i < int'(NPORT); i++)
      nerr[i] = v[i] && h[i] && ($countones(fw[i*NPORT +: NPORT]) != 1);
    for (int o = 0; o < int'(NPORT); o++) begin
      nown[o] = own[o];
      if (own[o] < 0) begin
        for (int k = 1; k <= int'(NPORT); k++) begin
          int c;
          c = (ptr[o] + k) % int'(NPORT);
          if (nown[o] < 0 && v[c] && h[c] && !busy[c] &&
              $countones(fw[c*NPORT +: NPORT]) == 1 && fw[c*NPORT + o])
            nown[o] = c;
        end
      end else if (xfer[o] && t[own[o]]) begin
        nown[o] = -1;
        ptr[o]  = own[o];
      end
    end
    for (int o = 0; o < int'(NPORT); o++) own[o] = nown[o];
    // Popped flits leave; bad heads and stray body flits are flushed by upstream.
    for (int i = 0; i < int'(NPORT); i++) begin
      if (pop[i] || nerr[i] || (v[i] && !h[i] && !busy[i])) void'(fq[i].pop_front());
    end
    err_m = nerr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_n(input int n);
    for (int c = 0; c < n; c++) run_cycle(ALL1, ALL1, 1'b0);
  endtask

  initial begin
    bus.in_valid  = '0;
    bus.in_head   = '0;
    bus.in_tail   = '0;
    bus.in_fwd    = '0;
    bus.out_ready = '0;
    model_reset();
    @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;

    // Single-flit IP -> E.
    push_pkt(int'(IDX_IP), 1, 7'(1) << IDX_E);
    run_n(4);

    // W and N contend for IP.
    push_pkt(int'(IDX_W), 3, 7'(1) << IDX_IP);
    push_pkt(int'(IDX_N), 3, 7'(1) << IDX_IP);
    run_n(10);

    // Backpressure on a 4-flit packet.
    push_pkt(int'(IDX_E), 4, 7'(1) << IDX_S);
    for (int c = 0; c < 8; c++) run_cycle((c == 2 || c == 3) ? 7'd0 : ALL1, ALL1, 1'b0);

    // Fairness: 1, 3, 5 stream single-flit packets to U.
    for (int p = 0; p < 10; p++) begin
      push_pkt(1, 1, 7'(1) << IDX_U);
      push_pkt(3, 1, 7'(1) << IDX_U);
      push_pkt(5, 1, 7'(1) << IDX_U);
    end
    run_n(66);

    // Route error on S.
    push_pkt(int'(IDX_S), 1, 7'b0000011);
    run_n(3);

    // Reset during flit 2 of a 5-flit packet, then fresh heads.
    push_pkt(int'(IDX_IP), 5, 7'(1) << IDX_U);
    run_n(2);
    run_cycle(ALL1, ALL1, 1'b1);
    push_pkt(int'(IDX_W), 2, 7'(1) << IDX_U);
    push_pkt(int'(IDX_D), 2, 7'(1) << IDX_U);
    run_n(12);

    // Randomized traffic with random gaps and backpressure.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic [NPORT-1:0] rdy, vm, bad;
      for (int i = 0; i < int'(NPORT); i++) begin
        rdy[i] = ($urandom_range(0, 99) < 80);
        vm[i]  = ($urandom_range(0, 99) < 85);
        if (fq[i].size() == 0 && $urandom_range(0, 99) < 30) begin
          if ($urandom_range(0, 19) == 0) begin
            int a, b;
            a = $urandom_range(0, 6);
            b = (a + 1 + $urandom_range(0, 5)) % 7;
            bad = '0;
            if ($urandom_range(0, 1) == 1) begin
              bad[a] = 1'b1;
              bad[b] = 1'b1;
            end
            push_pkt(i, 1, bad);
          end else begin
            push_pkt(i, $urandom_range(1, 4), 7'(1) << $urandom_range(0, 6));
          end
        end
      end
      run_cycle(rdy, vm, cyc == 700);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
